// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_prog
// Description : Runtime-programmable serial bit-pattern detector with
//               overlap control, valid qualifier and saturating match count.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         din_valid,
    input  logic                         din,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clear,
    output logic                         dout,
    output logic [CNT_W-1:0]             match_count,
    output logic                         armed
);

    localparam int LEN_W = $clog2(MAX_LEN+1);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_dout;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_enabled;
    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_n;
    logic               w_hit;
    logic               w_count_hit;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_unused_hist_msb;

    // The oldest history bit only ever shifts out; it never takes part in a compare.
    assign w_unused_hist_msb = r_hist[MAX_LEN-1];

    assign w_enabled = (r_len != '0) && (r_len <= c_max_len);
    assign w_cand    = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_n  = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hit       = w_enabled && (w_fill_n >= r_len) &&
                         (((w_cand ^ r_pat) & w_mask) == '0);
    assign w_count_hit = din_valid && !cfg_load && w_hit;

    // Clear takes effect first so a coincident hit leaves the count at one.
    always_comb begin
        w_cnt_next = cnt_clear ? '0 : r_cnt;
        if (w_count_hit && (w_cnt_next != c_cnt_max)) begin
            w_cnt_next = w_cnt_next + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pat  <= '0;
            r_len  <= '0;
            r_ovl  <= 1'b0;
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= cfg_len;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
                r_dout <= 1'b0;
            end else if (din_valid) begin
                r_hist <= w_cand;
                r_dout <= w_hit;
                r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_n;
            end else begin
                r_dout <= 1'b0;
            end
        end
    end

    assign dout        = r_dout;
    assign match_count = r_cnt;
    assign armed       = w_enabled && (r_fill >= r_len);

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_prog
// Description : Self-checking bench for seq_detector_prog against a
//               bit-history reference model; directed cases plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             cfg_load = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clear = 1'b0;
    logic             dout;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remembers the received bits and how many are usable
    bit        q[$];
    int        m_avail = 0;
    logic [7:0] m_pat = '0;
    int        m_len = 0;
    bit        m_ovl = 0;
    bit        m_dout = 0;
    int        m_cnt = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .dout(dout), .match_count(match_count), .armed(armed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_enabled();
        return (m_len >= 1) && (m_len <= MAX_LEN);
    endfunction

    function automatic bit tail_matches();
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size()-1-k] != m_pat[k]) return 0;
        end
        return 1;
    endfunction

    task automatic tick();
        bit hit;
        @(posedge clk);
        #1;
        hit = 0;
        if (!resetn) begin
            q.delete(); m_avail = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_dout = 0; m_cnt = 0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                q.delete(); m_avail = 0; m_dout = 0;
            end else if (din_valid) begin
                q.push_back(din);
                if (q.size() > 16) void'(q.pop_front());
                m_avail++;
                hit = m_enabled() && (m_avail >= m_len) && tail_matches();
                m_dout = hit;
                if (hit && !m_ovl) m_avail = 0;
            end else begin
                m_dout = 0;
            end
            if (cnt_clear) m_cnt = 0;
            if (hit && m_cnt < CNT_MAX) m_cnt++;
        end
        check("dout", dout, m_dout);
        check("match_count", match_count, m_cnt);
        check("armed", armed, m_enabled() && (m_avail >= m_len));
    endtask

    task automatic load(input logic [7:0] pat, input int len, input bit ovl);
        cfg_load = 1; cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ovl;
        cnt_clear = 1; din_valid = 1; din = 1'($urandom);
        tick();
        cfg_load = 0; cnt_clear = 0; din_valid = 0;
    endtask

    task automatic send(input bit d);
        din_valid = 1; din = d;
        tick();
        din_valid = 0;
    endtask

    task automatic idle(input int n);
        din_valid = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("gap_dout", dout, 0);
        end
    endtask

    initial begin
        bit b1010[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

        resetn = 0;
        tick();
        tick();
        check("rst_dout", dout, 0);
        check("rst_cnt", match_count, 0);
        check("rst_armed", armed, 0);
        resetn = 1;

        // 1: overlapping 1010
        load(8'b1010, 4, 1);
        for (int i = 0; i < 6; i++) begin
            send(b1010[i]);
            if (i == 3 || i == 5) check("t1_hit", dout, 1);
        end
        check("t1_cnt", match_count, 2);

        // 2: non-overlapping 1010
        load(8'b1010, 4, 0);
        for (int i = 0; i < 8; i++) begin
            send(b1010[i]);
            check("t2_dout", dout, (i == 3 || i == 7) ? 1 : 0);
        end
        check("t2_cnt", match_count, 2);

        // 3: test 1 with gaps
        load(8'b1010, 4, 1);
        for (int i = 0; i < 6; i++) begin
            send(b1010[i]);
            check("t3_dout", dout, (i == 3 || i == 5) ? 1 : 0);
            idle($urandom_range(1, 3));
        end
        check("t3_cnt", match_count, 2);

        // 4: reload mid-pattern restarts detection
        load(8'b1010, 4, 1);
        send(1); send(0); send(1);
        load(8'b1010, 4, 1);
        send(0);
        check("t4_nohit", dout, 0);
        for (int i = 0; i < 4; i++) send(b1010[i]);
        check("t4_hit", dout, 1);

        // 5: saturation and clear+hit
        load(8'b1, 1, 1);
        for (int i = 0; i < 5; i++) send(1);
        check("t5_sat", match_count, 3);
        cnt_clear = 1;
        send(1);
        cnt_clear = 0;
        check("t5_clr_hit", match_count, 1);

        // 6: disabled lengths, full length, mid-stream reset
        load(8'hFF, 0, 1);
        for (int i = 0; i < 12; i++) send(1);
        check("t6_len0", match_count, 0);
        load(8'hFF, MAX_LEN + 1, 1);
        for (int i = 0; i < 12; i++) send(1);
        check("t6_len9", match_count, 0);
        load(8'hFF, MAX_LEN, 1);
        for (int i = 0; i < 10; i++) begin
            send(1);
            check("t6_full", dout, (i >= MAX_LEN - 1) ? 1 : 0);
        end
        resetn = 0;
        tick();
        resetn = 1;
        check("t6_rst_dout", dout, 0);
        check("t6_rst_cnt", match_count, 0);
        check("t6_rst_armed", armed, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 25) begin
                int len;
                len = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 15);
                load(8'($urandom), len, 1'($urandom));
            end else begin
                resetn    = (r >= 28);
                cnt_clear = ($urandom_range(0, 29) == 0);
                din_valid = ($urandom_range(0, 9) < 7);
                din       = 1'($urandom);
                tick();
                resetn = 1; cnt_clear = 0; din_valid = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
